// File: rtl/afficheur_multiplex.sv
// afficheur_multiplex
// Multiplexed N-digit 7-segment display driver. A packed BCD value and its
// decimal points are captured on a one-cycle load strobe, then the digits are
// scanned one slot at a time on shared segment lines. Each slot begins with a
// short guard window with every digit enable off, so the previous digit's
// pattern never ghosts onto the next digit. Leading zeros can be blanked, and
// non-BCD codes are shown as a dash.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high
//   load   in   strobe: capture value / dp_in
//   value  in   packed BCD, digit i = value[4i+3:4i], digit 0 least significant
//   dp_in  in   decimal point request per digit
//   seg    out  segments a..g on bits 0..6, polarity set by POLARITE
//   dp     out  decimal point segment, same polarity as seg
//   an     out  digit enables, polarity set by POLARITE_AN
module afficheur_multiplex #(
    parameter int NB_DIGITS   = 4,
    parameter int DIV_REFRESH = 50000,
    parameter int GUARD       = 16,
    parameter int POLARITE    = 1,
    parameter int POLARITE_AN = 1,
    parameter int BLANK_ZERO  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [4*NB_DIGITS-1:0] value,
    input  logic [NB_DIGITS-1:0]   dp_in,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [NB_DIGITS-1:0]   an
);

    localparam int CW = (DIV_REFRESH > 1) ? $clog2(DIV_REFRESH) : 1;
    localparam int IW = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
    localparam logic SEG_INV = (POLARITE != 0);
    localparam logic AN_INV  = (POLARITE_AN != 0);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_REFRESH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB_DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*NB_DIGITS-1:0] disp;
    logic [NB_DIGITS-1:0]   dpl;
    logic [NB_DIGITS-1:0]   blank;

    logic [3:0]           digit;
    logic                 digit_blank;
    logic                 digit_dp;
    logic [6:0]           pattern;
    logic                 guard_done;
    logic [NB_DIGITS-1:0] onehot;
    logic [NB_DIGITS-1:0] blank_new;
    logic                 zero_above;

    // Select the current digit's code, blank flag and decimal point.
    always_comb begin
        digit       = '0;
        digit_blank = 1'b0;
        digit_dp    = 1'b0;
        for (int i = 0; i < NB_DIGITS; i++) begin
            if (idx == i[IW-1:0]) begin
                digit       = disp[4*i +: 4];
                digit_blank = blank[i];
                digit_dp    = dpl[i];
            end
        end
    end

    // Active-high abcdefg pattern; bit 6 is segment a, bit 0 is segment g
    // in this table, reversed onto seg[0..6] = a..g below.
    logic [6:0] abcdefg;
    always_comb begin
        abcdefg = 7'b0000001;
        unique case (digit)
            4'd0:    abcdefg = 7'b1111110;
            4'd1:    abcdefg = 7'b0110000;
            4'd2:    abcdefg = 7'b1101101;
            4'd3:    abcdefg = 7'b1111001;
            4'd4:    abcdefg = 7'b0110011;
            4'd5:    abcdefg = 7'b1011011;
            4'd6:    abcdefg = 7'b1011111;
            4'd7:    abcdefg = 7'b1110000;
            4'd8:    abcdefg = 7'b1111111;
            4'd9:    abcdefg = 7'b1111011;
            default: abcdefg = 7'b0000001;
        endcase
        if (digit_blank) begin
            abcdefg = 7'b0000000;
        end
        for (int s = 0; s < 7; s++) begin
            pattern[s] = abcdefg[6-s];
        end
    end

    always_comb begin
        guard_done = (int'({1'b0, cnt}) >= GUARD);
        onehot     = '0;
        for (int i = 0; i < NB_DIGITS; i++) begin
            onehot[i] = guard_done && (idx == i[IW-1:0]);
        end
    end

    // Digit i is blank when it and every digit above it are zero; walking
    // from the top keeps a running "all zero so far" flag.
    always_comb begin
        blank_new  = '0;
        zero_above = 1'b1;
        for (int i = NB_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above && (value[4*i +: 4] == 4'd0);
            blank_new[i] = (BLANK_ZERO != 0) && zero_above && (i != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            disp  <= '0;
            dpl   <= '0;
            blank <= ~NB_DIGITS'(1);
            seg   <= {7{SEG_INV}};
            dp    <= SEG_INV;
            an    <= {NB_DIGITS{AN_INV}};
        end else begin
            seg <= SEG_INV ? ~pattern : pattern;
            dp  <= SEG_INV ? ~digit_dp : digit_dp;
            an  <= AN_INV ? ~onehot : onehot;

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load) begin
                disp  <= value;
                dpl   <= dp_in;
                blank <= blank_new;
            end
        end
    end

endmodule

// File: tb/tb_afficheur_multiplex.sv
// tb_afficheur_multiplex
// Two instances share the stimulus: one common-anode / active-low enables,
// one common-cathode / active-high enables. Each cycle the expected
// active-high outputs are predicted from a small reference model and queued;
// after the edge they are popped and compared against both instances.
module tb_afficheur_multiplex;

    localparam int NB    = 4;
    localparam int DIV   = 4;
    localparam int GUARD = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;

    logic [6:0] seg_a, seg_c;
    logic       dp_a, dp_c;
    logic [3:0] an_a, an_c;

    always #5 clk = ~clk;

    afficheur_multiplex #(
        .NB_DIGITS(NB), .DIV_REFRESH(DIV), .GUARD(GUARD),
        .POLARITE(1), .POLARITE_AN(1), .BLANK_ZERO(1)
    ) dut_a (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    afficheur_multiplex #(
        .NB_DIGITS(NB), .DIV_REFRESH(DIV), .GUARD(GUARD),
        .POLARITE(0), .POLARITE_AN(0), .BLANK_ZERO(1)
    ) dut_c (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg_c), .dp(dp_c), .an(an_c)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Active-high patterns indexed by code, seg[0..6] = a..g.
    logic [6:0] seg_tab [16];

    int          m_cnt, m_idx;
    logic [15:0] m_disp;
    logic [3:0]  m_dpl, m_blank;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] rev7(input logic [6:0] abcdefg);
        logic [6:0] r;
        for (int s = 0; s < 7; s++) r[s] = abcdefg[6-s];
        return r;
    endfunction

    function automatic logic [3:0] blank_of(input logic [15:0] v);
        logic [3:0] b;
        b[0] = 1'b0;
        for (int i = 1; i < NB; i++) b[i] = ((v >> (4*i)) == 16'd0);
        return b;
    endfunction

    function automatic exp_t predict(input logic r);
        exp_t e;
        logic [3:0] d;
        e = '0;
        if (!r) begin
            d     = m_disp[4*m_idx +: 4];
            e.seg = m_blank[m_idx] ? 7'b0000000 : seg_tab[d];
            e.dp  = m_dpl[m_idx];
            e.an  = (m_cnt >= GUARD) ? (4'b0001 << m_idx) : 4'b0000;
        end
        return e;
    endfunction

    task automatic model_update(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        if (r) begin
            m_cnt = 0; m_idx = 0; m_disp = '0; m_dpl = '0; m_blank = 4'b1110;
        end else begin
            if (l) begin
                m_disp = v; m_dpl = d; m_blank = blank_of(v);
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % NB;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
        exp_t       e;
        logic [6:0] es_inv;
        logic       ed_inv;
        logic [3:0] ea_inv;
        @(negedge clk);
        reset = r; load = l; value = v; dp_in = d;
        sb.push_back(predict(r));
        model_update(r, l, v, d);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e      = sb.pop_front();
            es_inv = ~e.seg;
            ed_inv = ~e.dp;
            ea_inv = ~e.an;
            chk("seg_ca", seg_a, es_inv);
            chk("dp_ca",  dp_a,  ed_inv);
            chk("an_ca",  an_a,  ea_inv);
            chk("seg_cc", seg_c, e.seg);
            chk("dp_cc",  dp_c,  e.dp);
            chk("an_cc",  an_c,  e.an);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        step(1'b0, 1'b1, v, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        seg_tab[0]  = rev7(7'b1111110); seg_tab[1]  = rev7(7'b0110000);
        seg_tab[2]  = rev7(7'b1101101); seg_tab[3]  = rev7(7'b1111001);
        seg_tab[4]  = rev7(7'b0110011); seg_tab[5]  = rev7(7'b1011011);
        seg_tab[6]  = rev7(7'b1011111); seg_tab[7]  = rev7(7'b1110000);
        seg_tab[8]  = rev7(7'b1111111); seg_tab[9]  = rev7(7'b1111011);
        for (int c = 10; c < 16; c++) seg_tab[c] = rev7(7'b0000001);
        m_cnt = 0; m_idx = 0; m_disp = '0; m_dpl = '0; m_blank = 4'b1110;

        // Reset held three cycles, one of them with a load that must be ignored.
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        step(1'b1, 1'b1, 16'h9999, 4'hF);
        step(1'b1, 1'b0, 16'h0000, 4'h0);

        // Guard cycle, then digit 0 enabled showing "0".
        idle(1);
        chk("rel_an_guard", an_a, 4'b1111);
        idle(1);
        chk("rel_an_first", an_a, 4'b1110);
        chk("rel_seg_zero", seg_a, 7'b1000000);
        idle(10);

        do_load(16'h1234, 4'b0100);
        idle(18);

        do_load(16'h0070, 4'b0000);
        idle(17);

        do_load(16'h0000, 4'b0000);
        idle(16);
        do_load(16'h0A05, 4'b1001);
        idle(17);

        // Load coinciding with a slot change.
        for (int k = 0; k < DIV && m_cnt != DIV - 1; k++) idle(1);
        do_load(16'h5678, 4'b0010);
        idle(9);

        // Reset mid-frame, then release.
        idle(5);
        step(1'b1, 1'b0, 16'hFFFF, 4'hF);
        idle(10);

        for (int t = 0; t < 12; t++) begin
            do_load(16'($urandom), 4'($urandom));
            idle(int'($urandom_range(1, 20)));
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
